// File: rtl/hyperbus_pkg.sv
// Shared types and the chunk-size helper for the HyperBus burst splitter.
package hyperbus_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } split_state_e;

  // Fields are sized for the widest supported build; the top slices them down.
  typedef struct packed {
    logic [7:0]  cs;
    logic [31:0] addr;
    logic [15:0] len;
    logic        write;
    logic        last;
  } txn_t;

  // Words to emit next: stop at the next MaxBurst-aligned boundary or at the end.
  function automatic logic [31:0] calc_chunk(input logic [31:0] word_addr,
                                             input logic [31:0] remaining,
                                             input int unsigned mb_log2);
    logic [31:0] span;
    logic [31:0] room;
    span = 32'd1 << mb_log2;
    room = span - (word_addr & (span - 32'd1));
    return (remaining < room) ? remaining : room;
  endfunction

endpackage

// File: rtl/hyperbus_burst_splitter.sv
// Cuts linear word bursts into MaxBurst-aligned, chip-local HyperBus transactions.
// Optional request/split counters are built when HYPERBUS_SPLIT_STATS_EN is defined.
module hyperbus_burst_splitter
  import hyperbus_pkg::*;
#(
  parameter int AddrWidth    = 32,
  parameter int LenWidth     = 16,
  parameter int NumChips     = 2,
  parameter int ChipSizeLog2 = 23,
  parameter int MaxBurstLog2 = 8,
  localparam int CsW = (NumChips > 1) ? $clog2(NumChips) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [AddrWidth-1:0]    req_addr_i,
  input  logic [LenWidth-1:0]     req_len_i,
  input  logic                    req_write_i,
  output logic                    txn_valid_o,
  input  logic                    txn_ready_i,
  output logic [CsW-1:0]          txn_cs_o,
  output logic [ChipSizeLog2-2:0] txn_addr_o,
  output logic [MaxBurstLog2-1:0] txn_len_o,
  output logic                    txn_write_o,
`ifdef HYPERBUS_SPLIT_STATS_EN
  output logic [31:0]             stat_req_o,
  output logic [31:0]             stat_split_o,
`endif
  output logic                    txn_last_o
);

  localparam int WaW  = AddrWidth - 1;
  localparam int RemW = LenWidth + 1;
  localparam int LocW = ChipSizeLog2 - 1;

  split_state_e    state_q, state_d;
  logic [WaW-1:0]  word_addr_q, word_addr_d;
  logic [RemW-1:0] remaining_q, remaining_d;
  logic            write_q, write_d;

  logic [31:0]     chunk;
  logic [WaW-1:0]  cs_shift;
  txn_t            txn;

  always_comb begin
    state_d     = state_q;
    word_addr_d = word_addr_q;
    remaining_d = remaining_q;
    write_d     = write_q;
    txn         = '0;
    chunk       = calc_chunk(32'(word_addr_q), 32'(remaining_q), MaxBurstLog2);
    cs_shift    = word_addr_q >> LocW;

    // Fields are forced to zero outside ISSUE so idle outputs match reset.
    if (state_q == ST_ISSUE) begin
      txn.cs    = (NumChips > 1) ? 8'(cs_shift[CsW-1:0]) : 8'd0;
      txn.addr  = 32'(word_addr_q[LocW-1:0]);
      txn.len   = 16'(chunk - 32'd1);
      txn.write = write_q;
      txn.last  = (chunk == 32'(remaining_q));
    end

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          word_addr_d = req_addr_i[AddrWidth-1:1];
          remaining_d = RemW'(req_len_i) + RemW'(1);
          write_d     = req_write_i;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (txn_ready_i) begin
          word_addr_d = word_addr_q + WaW'(chunk);
          remaining_d = remaining_q - RemW'(chunk);
          if (txn.last) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      word_addr_q <= '0;
      remaining_q <= '0;
      write_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_addr_q <= word_addr_d;
      remaining_q <= remaining_d;
      write_q     <= write_d;
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign txn_valid_o = (state_q == ST_ISSUE);
  assign txn_cs_o    = txn.cs[CsW-1:0];
  assign txn_addr_o  = txn.addr[LocW-1:0];
  assign txn_len_o   = txn.len[MaxBurstLog2-1:0];
  assign txn_write_o = txn.write;
  assign txn_last_o  = txn.last;

  logic unused_bits;
  assign unused_bits = ^{req_addr_i[0], txn.cs, txn.addr, txn.len, cs_shift};

`ifdef HYPERBUS_SPLIT_STATS_EN
  logic [31:0] stat_req_q, stat_req_d;
  logic [31:0] stat_split_q, stat_split_d;

  always_comb begin
    stat_req_d   = stat_req_q;
    stat_split_d = stat_split_q;
    if (req_valid_i && req_ready_o) stat_req_d = stat_req_q + 32'd1;
    if (txn_valid_o && txn_ready_i && !txn_last_o) stat_split_d = stat_split_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_req_q   <= '0;
      stat_split_q <= '0;
    end else begin
      stat_req_q   <= stat_req_d;
      stat_split_q <= stat_split_d;
    end
  end

  assign stat_req_o   = stat_req_q;
  assign stat_split_o = stat_split_q;
`endif

endmodule

// File: tb/tb_hyperbus_burst_splitter.sv
// Directed bench for hyperbus_burst_splitter (default parameters).
module tb_hyperbus_burst_splitter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [15:0] req_len = '0;
  logic        req_write = 1'b0;
  logic        txn_valid;
  logic        txn_ready = 1'b1;
  logic [0:0]  txn_cs;
  logic [21:0] txn_addr;
  logic [7:0]  txn_len;
  logic        txn_write;
  logic        txn_last;
`ifdef HYPERBUS_SPLIT_STATS_EN
  logic [31:0] stat_req;
  logic [31:0] stat_split;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hyperbus_burst_splitter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_len_i   (req_len),
    .req_write_i (req_write),
    .txn_valid_o (txn_valid),
    .txn_ready_i (txn_ready),
    .txn_cs_o    (txn_cs),
    .txn_addr_o  (txn_addr),
    .txn_len_o   (txn_len),
    .txn_write_o (txn_write),
`ifdef HYPERBUS_SPLIT_STATS_EN
    .stat_req_o  (stat_req),
    .stat_split_o(stat_split),
`endif
    .txn_last_o  (txn_last)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request once ready; returns with the cycle after the handshake visible.
  task automatic send_req(input logic [31:0] addr, input logic [15:0] len, input logic wr);
    int n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("req_ready_wait", {63'd0, req_ready}, 64'd1);
    req_addr  = addr;
    req_len   = len;
    req_write = wr;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  // Check the presented transaction, then let it handshake.
  task automatic take(input string tag, input logic cs, input logic [21:0] addr,
                      input logic [7:0] len, input logic wr, input logic last);
    chk({tag, ".valid"}, {63'd0, txn_valid}, 64'd1);
    chk({tag, ".cs"},    {63'd0, txn_cs},    {63'd0, cs});
    chk({tag, ".addr"},  {42'd0, txn_addr},  {42'd0, addr});
    chk({tag, ".len"},   {56'd0, txn_len},   {56'd0, len});
    chk({tag, ".write"}, {63'd0, txn_write}, {63'd0, wr});
    chk({tag, ".last"},  {63'd0, txn_last},  {63'd0, last});
    chk({tag, ".rdy"},   {63'd0, req_ready}, 64'd0);
    step();
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".idle_rdy"}, {63'd0, req_ready}, 64'd1);
    chk({tag, ".idle_vld"}, {63'd0, txn_valid}, 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    txn_ready = 1'b1;
    do_reset();

    // Reset state
    chk("rst.ready", {63'd0, req_ready}, 64'd1);
    chk("rst.valid", {63'd0, txn_valid}, 64'd0);
    chk("rst.last",  {63'd0, txn_last},  64'd0);
    chk("rst.cs",    {63'd0, txn_cs},    64'd0);
    chk("rst.addr",  {42'd0, txn_addr},  64'd0);
    chk("rst.len",   {56'd0, txn_len},   64'd0);
    chk("rst.write", {63'd0, txn_write}, 64'd0);

    // Aligned read: word 0x80, single txn valid the cycle after handshake
    send_req(32'h100, 16'd15, 1'b0);
    take("aligned", 1'b0, 22'h80, 8'd15, 1'b0, 1'b1);
    check_idle("aligned");

    // Boundary split: word 0xF8, 8 words to the 256-word boundary
    send_req(32'h1F0, 16'd15, 1'b1);
    take("split1", 1'b0, 22'hF8, 8'd7, 1'b1, 1'b0);
    take("split2", 1'b0, 22'h100, 8'd7, 1'b1, 1'b1);
    check_idle("split");

    // Chip crossing: word 0x3FFFF8 runs into chip 1 at local 0
    send_req(32'h7FFFF0, 16'd15, 1'b0);
    take("chip1", 1'b0, 22'h3FFFF8, 8'd7, 1'b0, 1'b0);
    take("chip2", 1'b1, 22'h0, 8'd7, 1'b0, 1'b1);
    check_idle("chip");

    // Long burst: 65536 words -> 256 full transactions
    send_req(32'h0, 16'hFFFF, 1'b0);
    for (int i = 0; i < 256; i++) begin
      take("long", 1'b0, 22'(i * 256), 8'd255, 1'b0, (i == 255));
    end
    check_idle("long");

    // Backpressure on the first half of the split
    send_req(32'h1F0, 16'd15, 1'b1);
    txn_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp.valid", {63'd0, txn_valid}, 64'd1);
      chk("bp.addr",  {42'd0, txn_addr},  64'hF8);
      chk("bp.len",   {56'd0, txn_len},   64'd7);
      chk("bp.last",  {63'd0, txn_last},  64'd0);
      step();
    end
    txn_ready = 1'b1;
    take("bp1", 1'b0, 22'hF8, 8'd7, 1'b1, 1'b0);
    take("bp2", 1'b0, 22'h100, 8'd7, 1'b1, 1'b1);
    check_idle("bp");

    // Reset during the first split transaction
    send_req(32'h1F0, 16'd15, 1'b1);
    chk("rmid.valid_pre", {63'd0, txn_valid}, 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("rmid");
    chk("rmid.last", {63'd0, txn_last}, 64'd0);
    send_req(32'h100, 16'd15, 1'b0);
    take("rmid_aligned", 1'b0, 22'h80, 8'd15, 1'b0, 1'b1);
    check_idle("rmid_aligned");

`ifdef HYPERBUS_SPLIT_STATS_EN
    do_reset();
    chk("stat.req0",   {32'd0, stat_req},   64'd0);
    chk("stat.split0", {32'd0, stat_split}, 64'd0);
    send_req(32'h100, 16'd15, 1'b0);
    take("s_aligned", 1'b0, 22'h80, 8'd15, 1'b0, 1'b1);
    send_req(32'h1F0, 16'd15, 1'b1);
    take("s_split1", 1'b0, 22'hF8, 8'd7, 1'b1, 1'b0);
    take("s_split2", 1'b0, 22'h100, 8'd7, 1'b1, 1'b1);
    send_req(32'h7FFFF0, 16'd15, 1'b0);
    take("s_chip1", 1'b0, 22'h3FFFF8, 8'd7, 1'b0, 1'b0);
    take("s_chip2", 1'b1, 22'h0, 8'd7, 1'b0, 1'b1);
    chk("stat.req",   {32'd0, stat_req},   64'd3);
    chk("stat.split", {32'd0, stat_split}, 64'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hyperbus_burst_splitter.md
# hyperbus_burst_splitter

Front-end stage of the HyperBus controller that sits directly upstream of the PHY/transaction engine. It accepts linear word-burst requests from the AXI adapter and cuts each one into HyperBus transactions. No emitted transaction crosses a MaxBurst-aligned boundary or a chip boundary. Each transaction is tagged with its chip select and a chip-local word address.

## Interface
Parameters:
- AddrWidth, 32, byte address width of incoming requests
- LenWidth, 16, burst length field width (words minus one)
- NumChips, 2, number of HyperBus chips (power of two, ≥1)
- ChipSizeLog2, 23, log2 of bytes per chip
- MaxBurstLog2, 8, log2 of max words per emitted transaction; MaxBurstLog2 < ChipSizeLog2

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk_i  in  1  clock
  - rst_i  in  1  synchronous active-high reset
- Request side:
  - req_valid_i  in  1  request valid
  - req_ready_o  out  1  request accepted when high with valid
  - req_addr_i  in  AddrWidth  byte address; bit 0 ignored
  - req_len_i  in  LenWidth  words minus one
  - req_write_i  in  1  1 = write, 0 = read
- Transaction side:
  - txn_valid_o  out  1  transaction valid
  - txn_ready_i  in  1  downstream accepts
  - txn_cs_o  out  max(1,$clog2(NumChips))  chip index
  - txn_addr_o  out  ChipSizeLog2-1  chip-local word address
  - txn_len_o  out  MaxBurstLog2  words minus one
  - txn_write_o  out  1  copied from request
  - txn_last_o  out  1  final transaction of the request

## Operation
- States:
  - IDLE: req_ready_o=1, txn_valid_o=0. On req handshake, latch the word address (req_addr_i[AddrWidth-1:1]), remaining = req_len_i+1 (LenWidth+1 bits) and the write flag, then go to ISSUE.
  - ISSUE: req_ready_o=0, txn_valid_o=1.
- Transaction fields in ISSUE:
  - room = 2^MaxBurstLog2 − (word_addr mod 2^MaxBurstLog2)
  - chunk = min(remaining, room)
  - txn_len_o = chunk−1
  - txn_addr_o = word_addr[ChipSizeLog2-2:0]
  - txn_cs_o = word_addr bits directly above the chip-local field
  - txn_last_o = (chunk == remaining)
- On txn handshake:
  - word_addr += chunk
  - remaining −= chunk
  - If the handshake was with txn_last_o high, go to IDLE; otherwise stay in ISSUE.
- Address arithmetic and aliasing:
  - The word address wraps modulo 2^(AddrWidth−1).
  - Chip index bits above log2(NumChips) are ignored, so aliased addresses map to chip 0 upward.
  - MaxBurst divides the chip size, so the chunk rule alone guarantees no chip crossing.
- A request with req_len_i = max value yields 2^LenWidth words with no overflow (remaining is LenWidth+1 bits).

## Timing
- Reset values:
  - outputs: req_ready_o=1, txn_valid_o=0, txn_last_o=0, txn_cs_o=0, txn_addr_o=0, txn_len_o=0, txn_write_o=0
  - state: IDLE
- Latency: request handshake in cycle N gives txn_valid_o in N+1, with the first transaction valid.
- Throughput: one transaction per cycle while txn_ready_i is high. After the last handshake in cycle M, req_ready_o is high in M+1 (no request/transaction overlap).
- While txn_valid_o=1 and txn_ready_i=0, all txn_* outputs stay stable.
- Reset asserted mid-request: the in-flight request is dropped and state returns to IDLE in the next cycle.
- All outputs are registered or decoded from registered state only. There is no combinational path from req_* or txn_ready_i to any output.

## Configuration
- HYPERBUS_SPLIT_STATS_EN defined:
  - adds outputs stat_req_o [31:0] (accepted requests) and stat_split_o [31:0] (transactions emitted with txn_last_o=0)
  - both counters clear on rst_i and wrap at 2^32
- Undefined: these ports and their counters do not exist.

## Structure
- hyperbus_pkg holds:
  - the state enum
  - a packed struct for the txn fields (cs, addr, len, write, last)
  - the chunk-computation function
- No sub-module. The block is a single FSM plus datapath.

## Test plan
Parameters for all scenarios: MaxBurstLog2=8, ChipSizeLog2=23, NumChips=2, txn_ready_i=1 unless noted.
- Aligned read: addr 0x100, len 15 -> one txn: cs 0, addr 0x80, len 15, last 1, one cycle after the request handshake.
- Boundary split: write addr 0x1F0, len 15 -> txn 1: addr 0xF8, len 7, last 0; txn 2: addr 0x100, len 7, last 1; write=1 on both.
- Chip crossing: addr 0x7FFFF0, len 15 -> txn 1: cs 0, addr 0x3FFFF8, len 7; txn 2: cs 1, addr 0x0, len 7, last 1.
- Long burst: addr 0, len 0xFFFF -> 256 txns, each of len 255, only the final one with last 1; req_ready_o low throughout, high one cycle after the final handshake.
- Backpressure: hold txn_ready_i low for 5 cycles during the boundary-split scenario -> txn_* outputs constant, no txn skipped.
- Reset mid-op: assert rst_i during txn 1 of the boundary-split scenario -> next cycle txn_valid_o=0, req_ready_o=1; a fresh request then behaves as in the aligned-read scenario. With HYPERBUS_SPLIT_STATS_EN, run the first three scenarios back to back -> stat_req_o=3, stat_split_o=2.
